// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: drives a multiplexed common-anode 7-segment display.
// A value is loaded through a valid/ready handshake. It is then converted to BCD by
// shift-add-3 over DATA_W cycles, or taken as raw hex nibbles. The result is committed
// to a display register, and the display register is scanned one digit at a time by a
// free-running prescaler.
//
// Optional build macro: FND_LZ_BLANK_EN blanks leading zero digits. Digit 0 is never
// blanked, and nothing is blanked while the overflow indicator is set.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   data_in     unsigned value to display
//   data_valid  load request, taken only while ready
//   hex_mode    sampled with data_in: 1 = hex digits, 0 = decimal digits
//   dp_in       per-digit decimal point, active-high, not latched
//   ready       high while idle, when a load can be accepted
//   done        one-cycle pulse in the cycle before the display register updates
//   ovf         the last committed value did not fit the display
//   seg         active-low segments {dp, g..a}
//   seg_com     active-low one-hot digit select, bit 0 = least significant digit
module fnd_scan_controller #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  input  logic                  hex_mode,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic                  ready,
  output logic                  done,
  output logic                  ovf,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] seg_com
);

  localparam int unsigned AccW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [63:0] DecMax = 64'(10 ** NUM_DIGITS) - 64'd1;
  localparam logic [63:0] HexLim = 64'd1 << AccW;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] bin_q;
  logic [AccW-1:0]   acc_q;
  logic [AccW-1:0]   acc_adj;
  logic [AccW-1:0]   acc_shift;
  logic [AccW-1:0]   hex_val;
  logic [AccW-1:0]   disp_q;
  logic              hex_q;
  logic              ovf_lat_q;
  logic              ovf_q;
  logic              ovf_now;
  logic [CntW-1:0]   cnt_q;
  logic [PreW-1:0]   presc_q;
  logic [IdxW-1:0]   idx_q;
  logic [3:0]        cur_nib;
  logic              blank_now;
  logic [6:0]        seg_low;
  logic [7:0]        seg_q;
  logic [NUM_DIGITS-1:0] seg_com_q;
  logic [63:0]       din_ext;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (data_valid) state_d = StShift;
      StShift:  if (cnt_q == CntW'(DATA_W - 1)) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StCommit);
  end

  // ---------------- Conversion datapath ----------------
  // Overflow is decided on the raw input at accept time, so the truncated
  // accumulator contents never matter for an out-of-range value.
  always_comb begin
    din_ext = 64'(data_in);
    ovf_now = hex_mode ? (din_ext >= HexLim) : (din_ext > DecMax);
  end

  // Add 3 to each BCD nibble >= 5, then shift the next binary bit in.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[AccW-2:0], bin_q[DATA_W-1]};
  end

  if (AccW >= DATA_W) begin : g_hex_ext
    assign hex_val = AccW'(bin_q);
  end else begin : g_hex_trunc
    assign hex_val = bin_q[AccW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q     <= '0;
      acc_q     <= '0;
      hex_q     <= 1'b0;
      ovf_lat_q <= 1'b0;
      cnt_q     <= '0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (data_valid) begin
            bin_q     <= data_in;
            hex_q     <= hex_mode;
            ovf_lat_q <= ovf_now;
            acc_q     <= '0;
            cnt_q     <= '0;
          end
        end
        StShift: begin
          cnt_q <= cnt_q + 1'b1;
          // Hex mode keeps bin_q intact and only spends the same number of cycles.
          if (!hex_q) begin
            acc_q <= acc_shift;
            bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          end
        end
        StCommit: begin
          disp_q <= hex_q ? hex_val : acc_q;
          ovf_q  <= ovf_lat_q;
        end
        default: ;
      endcase
    end
  end

  assign ovf = ovf_q;

  // ---------------- Scan ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PreW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

`ifdef FND_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  upper_zero;

  // lz[i] is set when digit i and every digit above it are zero.
  always_comb begin
    lz         = '0;
    upper_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'd0);
      lz[i]      = upper_zero;
    end
  end

  assign blank_now = lz[idx_q] & ~ovf_q;
`else
  assign blank_now = 1'b0;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    if (ovf_q)          seg_low = 7'h3F;
    else if (blank_now) seg_low = 7'h7F;
    else                seg_low = seg_decode(cur_nib);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q     <= 8'hFF;
      seg_com_q <= '1;
    end else begin
      seg_q     <= {~dp_in[idx_q], seg_low};
      seg_com_q <= ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  assign seg     = seg_q;
  assign seg_com = seg_com_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (NUM_DIGITS=4, DATA_W=14, SCAN_DIV=4).
// Expected display contents come from digit arithmetic on the loaded value; the expected
// scan position comes from the number of clock edges since reset was released.
module tb_fnd_scan_controller;

  localparam int ND = 4;
  localparam int DW = 14;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          hex_mode = 1'b0;
  logic [ND-1:0] dp_in = '0;
  logic          ready, done, ovf;
  logic [7:0]    seg;
  logic [ND-1:0] seg_com;

  fnd_scan_controller #(
    .NUM_DIGITS(ND),
    .DATA_W    (DW),
    .SCAN_DIV  (SD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .hex_mode  (hex_mode),
    .dp_in     (dp_in),
    .ready     (ready),
    .done      (done),
    .ovf       (ovf),
    .seg       (seg),
    .seg_com   (seg_com)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned edges = 0;
  always @(posedge clk) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  // Reference model of what the display currently holds.
  int unsigned m_val = 0;
  bit          m_hex = 1'b0;
  bit          m_ovf = 1'b0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic void model_commit(input int unsigned v, input bit hx);
    m_val = v;
    m_hex = hx;
    m_ovf = hx ? (v >= (32'd1 << (4 * ND))) : (v > 10 ** ND - 1);
  endfunction

  function automatic int exp_idx();
    return int'(((edges - 1) / SD) % ND);
  endfunction

  function automatic logic [7:0] exp_seg(input int i);
    int unsigned base = m_hex ? 16 : 10;
    int unsigned p = 1;
    int unsigned d;
    for (int k = 0; k < i; k++) p = p * base;
    d = (m_val / p) % base;
    if (m_ovf) return {~dp_in[i], 7'h3F};
`ifdef FND_LZ_BLANK_EN
    if (i > 0 && (m_val / p) == 0) return {~dp_in[i], 7'h7F};
`endif
    return {~dp_in[i], segtab[d]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int unsigned v, input bit hx);
    data_in    = DW'(v);
    hex_mode   = hx;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Counts busy cycles after the accept edge; returns once ready is back (bounded).
  task automatic wait_idle(output int lowc, output int done_at, output int ndone);
    lowc = 0; done_at = -1; ndone = 0;
    while (!ready && lowc < 40) begin
      lowc++;
      if (done) begin ndone++; done_at = lowc; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", seg); end
      total++; if (seg_com !== 4'hF) begin bad++; $display("FAIL reset_com got=%b exp=1111", seg_com); end
      total++; if (ready !== 1'b1 || done !== 1'b0 || ovf !== 1'b0) begin
        bad++; $display("FAIL reset_flags got r=%b d=%b o=%b exp r=1 d=0 o=0", ready, done, ovf);
      end
    end
    reset_n = 1'b1;
    model_commit(0, 0);
    for (int k = 0; k < 5 * SD; k++) begin
      logic [ND-1:0] ec;
      tick();
      ec = ~(ND'(1) << exp_idx());
      total++; if (seg_com !== ec) begin bad++; $display("FAIL scan_com k=%0d got=%b exp=%b", k, seg_com, ec); end
      total++; if (seg !== exp_seg(exp_idx())) begin
        bad++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, exp_seg(exp_idx()));
      end
    end
  endtask

  task automatic test_load(input string nm, input int unsigned v, input bit hx,
                           input logic [ND-1:0] dp);
    int lowc, done_at, ndone;
    logic [ND-1:0] ec;
    dp_in = dp;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL %s_ready_pre got=%b exp=1", nm, ready); end
    start_load(v, hx);
    wait_idle(lowc, done_at, ndone);
    total++; if (lowc !== DW + 1) begin bad++; $display("FAIL %s_busy got=%0d exp=%0d", nm, lowc, DW + 1); end
    total++; if (ndone !== 1 || done_at !== DW + 1) begin
      bad++; $display("FAIL %s_done got n=%0d at=%0d exp n=1 at=%0d", nm, ndone, done_at, DW + 1);
    end
    model_commit(v, hx);
    total++; if (ovf !== m_ovf) begin bad++; $display("FAIL %s_ovf got=%b exp=%b", nm, ovf, m_ovf); end
    for (int k = 0; k < ND * SD; k++) begin
      tick();
      ec = ~(ND'(1) << exp_idx());
      total++; if (seg_com !== ec) begin bad++; $display("FAIL %s_com got=%b exp=%b", nm, seg_com, ec); end
      total++; if (seg !== exp_seg(exp_idx())) begin
        bad++; $display("FAIL %s_seg digit=%0d got=%h exp=%h", nm, exp_idx(), seg, exp_seg(exp_idx()));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      bit hx = 1'($urandom_range(0, 1));
      int unsigned v = $urandom_range(0, (1 << DW) - 1);
      if (!hx && n < 5) v = $urandom_range(0, 9999);
      test_load("rand", v, hx, ND'($urandom_range(0, (1 << ND) - 1)));
    end
  endtask

  task automatic test_ignore_busy();
    int lowc, done_at, ndone;
    dp_in = '0;
    start_load(1234, 0);
    repeat (4) tick();
    data_in = DW'(5678);
    data_valid = 1'b1;
    tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", ready); end
    tick();
    data_valid = 1'b0;
    wait_idle(lowc, done_at, ndone);
    total++; if (lowc !== DW + 1 - 6 || ndone !== 1) begin
      bad++; $display("FAIL busy_len got low=%0d n=%0d exp low=%0d n=1", lowc, ndone, DW + 1 - 6);
    end
    model_commit(1234, 0);
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL busy_noqueue got=%b exp=1", ready); end
    for (int k = 0; k < ND * SD; k++) begin
      tick();
      total++; if (seg !== exp_seg(exp_idx())) begin
        bad++; $display("FAIL busy_seg got=%h exp=%h", seg, exp_seg(exp_idx()));
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    start_load(4321, 0);
    repeat (7) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (ready !== 1'b1 || seg !== 8'hFF) begin
      bad++; $display("FAIL rstmid_state got r=%b seg=%h exp r=1 seg=ff", ready, seg);
    end
    model_commit(0, 0);
    for (int k = 0; k < 2 * ND * SD; k++) begin
      tick();
      if (done) ndone++;
      total++; if (seg !== exp_seg(exp_idx())) begin
        bad++; $display("FAIL rstmid_seg got=%h exp=%h", seg, exp_seg(exp_idx()));
      end
    end
    total++; if (ndone !== 0 || ovf !== 1'b0) begin
      bad++; $display("FAIL rstmid_done got n=%0d o=%b exp n=0 o=0", ndone, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_load("dec1234", 1234, 0, 4'b0000);
    test_load("hex2bad", 32'h2BAD, 1, 4'b0000);
    test_load("ovf12000", 12000, 0, 4'b0100);
    test_load("hexbig", 32'h3FFF, 1, 4'b1001);
    test_load("dec9999", 9999, 0, 4'b0001);
    test_load("dec10000", 10000, 0, 4'b0000);
    test_ignore_busy();
    test_reset_mid();
    test_load("lz7", 7, 0, 4'b0000);
    test_load("zero", 0, 0, 4'b0010);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
